// File: rtl/imu_spi_pkg.sv
// Shared types and command words for the IMU SPI sequencer.
// Optional macro IMU_PITCH_RD_EN adds the pitch-rate read states.
package imu_spi_pkg;

    // Configuration writes (READ bit 15 clear)
    localparam logic [15:0] CMD_CFG_INT  = 16'h0D02;  // interrupt on data ready
    localparam logic [15:0] CMD_CFG_GYRO = 16'h1160;  // gyro 416 Hz, 250 dps
    localparam logic [15:0] CMD_CFG_CTRL = 16'h1440;  // auto-increment / rounding

    // Register reads (READ bit 15 set, address in [14:8])
    localparam logic [15:0] CMD_RD_YAWL  = 16'hA600;
    localparam logic [15:0] CMD_RD_YAWH  = 16'hA700;
    localparam logic [15:0] CMD_RD_PITL  = 16'hA200;
    localparam logic [15:0] CMD_RD_PITH  = 16'hA300;

    typedef enum logic [3:0] {
        PWR_WAIT,
        CFG0,
        CFG1,
        CFG2,
        WAIT_INT,
        RD_YL,
        RD_YH
`ifdef IMU_PITCH_RD_EN
        ,
        RD_PL,
        RD_PH
`endif
    } imu_state_e;

    // Command word issued on entry to a state; zero for states without SPI traffic
    function automatic logic [15:0] state_cmd(input imu_state_e s);
        logic [15:0] c;
        case (s)
            CFG0:    c = CMD_CFG_INT;
            CFG1:    c = CMD_CFG_GYRO;
            CFG2:    c = CMD_CFG_CTRL;
            RD_YL:   c = CMD_RD_YAWL;
            RD_YH:   c = CMD_RD_YAWH;
`ifdef IMU_PITCH_RD_EN
            RD_PL:   c = CMD_RD_PITL;
            RD_PH:   c = CMD_RD_PITH;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Every SPI command word is non-zero, so a non-zero command marks an SPI state
    function automatic logic is_spi_state(input imu_state_e s);
        return state_cmd(s) != '0;
    endfunction

endpackage

// File: rtl/imu_spi_seq_if.sv
// Handshake between the IMU sequencer and the 16-bit SPI master.
interface imu_spi_seq_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    // Sequencer side: issues commands, consumes completion and read data
    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    // SPI master side
    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus a history flop giving a rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Shift the asynchronous input through the synchroniser chain
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchroniser and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/imu_spi_seq.sv
// IMU SPI sequencer: power-up wait, three configuration writes, then
// yaw-rate reads on each data-ready interrupt.
// Optional macro IMU_PITCH_RD_EN: also read pitch rate and strobe vld once
// after both rates are captured.
module imu_spi_seq
    import imu_spi_pkg::*;
#(
    parameter int unsigned TMR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INT,
    imu_spi_seq_if.master        spi,
    output logic [15:0]          yaw_rt,
    output logic                 vld,
    output logic [15:0]          pitch_rt,
    output logic                 cfg_done
);

    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    imu_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             done_q, done_d;
    logic             wrt_q, wrt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             vld_q, vld_d;
    logic [15:0]      yaw_q, yaw_d;
    logic [7:0]       yawl_q, yawl_d;
    logic             cfg_done_q, cfg_done_d;
`ifdef IMU_PITCH_RD_EN
    logic [7:0]       yawh_q, yawh_d;
    logic [7:0]       pitl_q, pitl_d;
    logic [15:0]      pitch_q, pitch_d;
`endif

    logic       int_rise;
    logic       done_rise;
    logic [7:0] rd_lo;
    logic       unused_rd_hi;

    sync_edge_det u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .rise  (int_rise)
    );

    assign done_rise    = spi.done & ~done_q;
    assign rd_lo        = spi.rd_data[7:0];
    assign unused_rd_hi = ^spi.rd_data[15:8];

    // Next-state, command and capture logic for the sequencer
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        done_d     = spi.done;
        wrt_d      = 1'b0;
        cmd_d      = cmd_q;
        vld_d      = 1'b0;
        yaw_d      = yaw_q;
        yawl_d     = yawl_q;
        cfg_done_d = cfg_done_q;
`ifdef IMU_PITCH_RD_EN
        yawh_d     = yawh_q;
        pitl_d     = pitl_q;
        pitch_d    = pitch_q;
`endif
        unique case (state_q)
            PWR_WAIT: begin
                timer_d = timer_q + TMR_ONE;
                if (&timer_q) begin
                    timer_d = '0;
                    state_d = CFG0;
                end
            end
            CFG0:     if (done_rise) state_d = CFG1;
            CFG1:     if (done_rise) state_d = CFG2;
            CFG2: begin
                if (done_rise) begin
                    state_d    = WAIT_INT;
                    cfg_done_d = 1'b1;
                end
            end
            WAIT_INT: if (int_rise) state_d = RD_YL;
            RD_YL: begin
                if (done_rise) begin
                    yawl_d  = rd_lo;
                    state_d = RD_YH;
                end
            end
`ifdef IMU_PITCH_RD_EN
            // Yaw is held back so both rates update together with one vld
            RD_YH: begin
                if (done_rise) begin
                    yawh_d  = rd_lo;
                    state_d = RD_PL;
                end
            end
            RD_PL: begin
                if (done_rise) begin
                    pitl_d  = rd_lo;
                    state_d = RD_PH;
                end
            end
            RD_PH: begin
                if (done_rise) begin
                    yaw_d   = {yawh_q, yawl_q};
                    pitch_d = {rd_lo, pitl_q};
                    vld_d   = 1'b1;
                    state_d = WAIT_INT;
                end
            end
`else
            RD_YH: begin
                if (done_rise) begin
                    yaw_d   = {rd_lo, yawl_q};
                    vld_d   = 1'b1;
                    state_d = WAIT_INT;
                end
            end
`endif
            default: state_d = PWR_WAIT;
        endcase

        // Single point that launches a transaction on entry to any SPI state
        if ((state_d != state_q) && is_spi_state(state_d)) begin
            wrt_d = 1'b1;
            cmd_d = state_cmd(state_d);
        end
    end

    // All sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PWR_WAIT;
            timer_q    <= '0;
            done_q     <= 1'b0;
            wrt_q      <= 1'b0;
            cmd_q      <= '0;
            vld_q      <= 1'b0;
            yaw_q      <= '0;
            yawl_q     <= '0;
            cfg_done_q <= 1'b0;
`ifdef IMU_PITCH_RD_EN
            yawh_q     <= '0;
            pitl_q     <= '0;
            pitch_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            vld_q      <= vld_d;
            yaw_q      <= yaw_d;
            yawl_q     <= yawl_d;
            cfg_done_q <= cfg_done_d;
`ifdef IMU_PITCH_RD_EN
            yawh_q     <= yawh_d;
            pitl_q     <= pitl_d;
            pitch_q    <= pitch_d;
`endif
        end
    end

    assign spi.wrt  = wrt_q;
    assign spi.cmd  = cmd_q;
    assign vld      = vld_q;
    assign yaw_rt   = yaw_q;
    assign cfg_done = cfg_done_q;
`ifdef IMU_PITCH_RD_EN
    assign pitch_rt = pitch_q;
`else
    assign pitch_rt = '0;
`endif

endmodule

// File: tb/tb_imu_spi_seq.sv
// Bench for imu_spi_seq with a short power-up wait (TMR_W=4) and a
// transaction-level SPI responder driven from the main thread.
module tb_imu_spi_seq;

    localparam int unsigned TMR_W   = 4;
    localparam int unsigned PWR_CYC = 16;

    typedef logic [7:0] bytes_t [4];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic [15:0] yaw_rt;
    logic        vld;
    logic [15:0] pitch_rt;
    logic        cfg_done;

    imu_spi_seq_if spi ();

    imu_spi_seq #(.TMR_W(TMR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .INT      (INT),
        .spi      (spi),
        .yaw_rt   (yaw_rt),
        .vld      (vld),
        .pitch_rt (pitch_rt),
        .cfg_done (cfg_done)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned wrt_count = 0;
    int unsigned vld_count = 0;

    // Reference model: command list for one interrupt service and result words
    logic [15:0] read_cmds[$];

    function automatic logic [15:0] model_yaw(input bytes_t b);
        return {b[1], b[0]};
    endfunction

    function automatic logic [15:0] model_pitch(input bytes_t b);
`ifdef IMU_PITCH_RD_EN
        return {b[3], b[2]};
`else
        return 16'h0000 & {b[3], b[2]};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event counters sampled just after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (spi.wrt === 1'b1) wrt_count++;
        if (vld === 1'b1) vld_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_wrt(input string tag, input bit toggle, output int unsigned n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (toggle) INT = 1'($urandom);
        end while (spi.wrt !== 1'b1 && n < 200);
        if (toggle) INT = 1'b0;
        if (spi.wrt !== 1'b1) check($sformatf("%s_timeout", tag), 64'd0, 64'd1);
    endtask

    // Called at the negedge where wrt is seen; answers after `hold` cycles
    task automatic xact(input logic [15:0] exp_cmd, input logic [7:0] byte_v,
                        input int unsigned hold, input bit toggle);
        check($sformatf("cmd_%h", exp_cmd), 64'(spi.cmd), 64'(exp_cmd));
        spi.done = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            if (toggle) INT = 1'($urandom);
            check("wrt_one_cycle", 64'(spi.wrt), 64'd0);
            check($sformatf("cmd_stable_%h", exp_cmd), 64'(spi.cmd), 64'(exp_cmd));
        end
        if (toggle) INT = 1'b0;
        spi.rd_data = {8'($urandom), byte_v};
        spi.done    = 1'b1;
    endtask

    task automatic run_config(input bit toggle);
        logic [15:0] cfg [3];
        int unsigned n;
        int unsigned v0;
        cfg[0] = 16'h0D02;
        cfg[1] = 16'h1160;
        cfg[2] = 16'h1440;
        v0 = vld_count;
        wait_wrt("pwr_wait", toggle, n);
        check("pwr_wait_len", 64'(n), 64'(PWR_CYC));
        for (int unsigned k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_wrt("cfg_next", 1'b0, n);
                check("cfg_gap", 64'(n), 64'd1);
            end
            check("cfg_done_early", 64'(cfg_done), 64'd0);
            xact(cfg[k], 8'($urandom),
                 (k == 2) ? 3 + $urandom_range(0, 3) : 1 + $urandom_range(0, 4),
                 toggle && (k < 2));
        end
        @(negedge clk);
        check("cfg_done", 64'(cfg_done), 64'd1);
        check("cfg_no_vld", 64'(vld_count), 64'(v0));
    endtask

    task automatic idle_check(input int unsigned cycles);
        int unsigned w0;
        w0 = wrt_count;
        repeat (cycles) @(negedge clk);
        check("idle_no_wrt", 64'(wrt_count), 64'(w0));
    endtask

    // mode 0: plain; 1: INT re-raised during first read and held; 2: extra INT pulse during first read
    task automatic service(input bytes_t b, input int unsigned mode);
        int unsigned n;
        int unsigned v0;
        v0 = vld_count;
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_wrt("int_lat", 1'b0, n);
        check("int_lat", 64'((n >= 2) && (n <= 3)), 64'd1);
        for (int unsigned k = 0; k < read_cmds.size(); k++) begin
            if (k > 0) begin
                wait_wrt("rd_next", 1'b0, n);
                check("rd_gap", 64'(n), 64'd1);
            end
            if (k == 0 && mode != 0) INT = 1'b1;
            xact(read_cmds[k], b[k], 1 + $urandom_range(0, 3), 1'b0);
            if (k == 0 && mode == 2) INT = 1'b0;
            check("no_early_vld", 64'(vld_count), 64'(v0));
        end
        @(negedge clk);
        check("vld", 64'(vld), 64'd1);
        check("yaw_rt", 64'(yaw_rt), 64'(model_yaw(b)));
        check("pitch_rt", 64'(pitch_rt), 64'(model_pitch(b)));
        @(negedge clk);
        check("vld_one_cycle", 64'(vld), 64'd0);
        check("yaw_hold", 64'(yaw_rt), 64'(model_yaw(b)));
        check("vld_count", 64'(vld_count), 64'(v0 + 1));
        if (mode != 0) idle_check(12);
    endtask

    initial begin
        bytes_t b;
        int unsigned n;

        read_cmds.push_back(16'hA600);
        read_cmds.push_back(16'hA700);
`ifdef IMU_PITCH_RD_EN
        read_cmds.push_back(16'hA200);
        read_cmds.push_back(16'hA300);
`endif

        rst_n       = 1'b0;
        INT         = 1'b0;
        spi.done    = 1'b0;
        spi.rd_data = '0;
        repeat (4) begin
            @(negedge clk);
            INT = ~INT;
        end
        INT = 1'b0;
        check("reset_outputs", 64'({spi.wrt, spi.cmd, vld, yaw_rt, pitch_rt, cfg_done}), 64'd0);
        rst_n = 1'b1;

        run_config(1'b1);
        idle_check(10);

        b = '{8'h34, 8'h12, 8'h56, 8'h78};
        service(b, 0);
        b = '{8'h00, 8'h80, 8'hFF, 8'h7F};
        service(b, 0);
        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        service(b, 0);
        repeat (6) begin
            foreach (b[i]) b[i] = 8'($urandom);
            service(b, 0);
        end

        foreach (b[i]) b[i] = 8'($urandom);
        service(b, 1);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        foreach (b[i]) b[i] = 8'($urandom);
        service(b, 0);
        foreach (b[i]) b[i] = 8'($urandom);
        service(b, 2);

        // Reset while the yaw high-byte read is outstanding
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_wrt("rst_rd_yl", 1'b0, n);
        xact(16'hA600, 8'h5A, 2, 1'b0);
        wait_wrt("rst_rd_yh", 1'b0, n);
        check("rst_in_rd_yh_cmd", 64'(spi.cmd), 64'(16'hA700));
        spi.done = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        spi.done = 1'b1;
        #1;
        check("reset_mid_outputs", 64'({spi.wrt, spi.cmd, vld, yaw_rt, pitch_rt, cfg_done}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_config(1'b0);
        foreach (b[i]) b[i] = 8'($urandom);
        service(b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
